// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit for the MIPS datapath. It executes MULTU,
// MULT, DIVU and DIV one bit per clock and holds the architectural HI/LO
// registers that feed the MFHI/MFLO writeback mux.
//
// Operation timeline (E0 = edge that accepts start):
//   E0      : IDLE -> RUN. Operand magnitudes, result signs and the
//             iteration counter are latched. busy rises.
//   E1..E32 : one shift-add (multiply) or restoring shift-subtract
//             (divide) step per edge.
//   E33     : FIX. Sign correction, HI/LO written, done pulses, busy falls.
//   E34     : first edge that can accept the next start.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request a new operation (ignored while busy)
//   op       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_data  multiplicand / dividend
//   rt_data  multiplier / divisor
//   abort    cancel the in-flight operation (pipeline flush)
//   hi_we    MTHI write enable (accepted only while not busy)
//   lo_we    MTLO write enable (accepted only while not busy)
//   wdata    MTHI/MTLO write data
//   busy     operation in progress
//   done     one-cycle pulse: HI/LO were just written by an operation
//   hi, lo   architectural HI/LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  // The most negative value maps onto itself, which is its correct
  // unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    logic [WIDTH-1:0] r;
    if (is_signed && v[WIDTH-1]) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Conditional two's-complement negation of a single-width value.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    logic [WIDTH-1:0] r;
    if (neg) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Conditional two's-complement negation of a double-width product.
  function automatic logic [DW-1:0] cond_neg_dw(input logic [DW-1:0] v,
                                                input logic          neg);
    logic [DW-1:0] r;
    if (neg) begin
      r = ~v + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_e           state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  // acc holds {partial product, multiplier} for MULT and
  // {partial remainder, dividend/quotient} for DIV.
  logic [DW-1:0]    acc_q,     acc_d;
  // b holds the multiplicand magnitude or the divisor magnitude.
  logic [WIDTH-1:0] b_q,       b_d;
  logic             is_div_q,  is_div_d;
  logic             neg_res_q, neg_res_d;   // product / quotient negative
  logic             neg_rem_q, neg_rem_d;   // remainder negative (dividend sign)
  logic             div0_q,    div0_d;      // divisor was zero
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  // Per-iteration datapath and decode of the incoming operands.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_diff;
  logic [DW-1:0]    mul_step;
  logic [DW-1:0]    div_step;
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             op_signed;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  // One shift-add / shift-subtract step plus the final sign fix-up values.
  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right,
    // keeping the carry out of the add.
    mul_sum = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, b_q};
    if (acc_q[0]) begin
      mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      mul_step = {1'b0, acc_q[DW-1:1]};
    end

    // Restoring division: trial-subtract the divisor from the remainder
    // shifted left by one (WIDTH+1 bits wide). No borrow means the trial
    // succeeded and a 1 quotient bit enters at the bottom. A zero divisor
    // never borrows, so the quotient becomes all ones and the remainder
    // ends up equal to the dividend magnitude.
    div_diff = {1'b0, acc_q[DW-1:WIDTH-1]} - {2'b00, b_q};
    if (!div_diff[WIDTH+1]) begin
      div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {acc_q[DW-2:0], 1'b0};
    end

    prod_fix = cond_neg_dw(acc_q, neg_res_q);
    rem_fix  = cond_neg(acc_q[DW-1:WIDTH], neg_rem_q);
    if (div0_q) begin
      quo_fix = {WIDTH{1'b1}};
    end else begin
      quo_fix = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
    end

    op_signed = op[0];
    rs_neg    = op_signed & rs_data[WIDTH-1];
    rt_neg    = op_signed & rt_data[WIDTH-1];
    rs_mag    = magnitude(rs_data, op_signed);
    rt_mag    = magnitude(rt_data, op_signed);
  end

  // Next-state and register-update logic for the IDLE/RUN/FIX sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // MTHI/MTLO are accepted whenever no operation is in flight,
        // including the cycle done is high; that write lands after the
        // FIX write and overwrites it.
        if (hi_we) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end

        // start beats a simultaneous abort: abort only acts on RUN/FIX.
        if (start) begin
          state_d   = S_RUN;
          busy_d    = 1'b1;
          cnt_d     = CW'(ITER);
          is_div_d  = op[1];
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          div0_d    = op[1] & (rt_data == {WIDTH{1'b0}});
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, rs_mag};
            b_d   = rt_mag;
          end else begin
            acc_d = {{WIDTH{1'b0}}, rt_mag};
            b_d   = rs_mag;
          end
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            acc_d = div_step;
          end else begin
            acc_d = mul_step;
          end
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
            state_d = S_FIX;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (abort) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[DW-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {DW{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// Testbench for muldiv_unit: directed scenarios plus randomized operations,
// checked through an expected-result queue drained by a monitor on done.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        abort;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;
  logic        prev_done = 1'b0;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .abort   (abort),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: MIPS semantics from plain arithmetic, returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ua;
    logic [63:0] ub;
    longint      p;
    int          q;
    int          r;
    case (o)
      2'b00: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
      end
      2'b01: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      check("done_one_cycle", {63'd0, prev_done}, 64'd0);
      check("busy_low_at_done", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h%h expected=no_result", hi, lo);
      end else begin
        check("result", {hi, lo}, exp_q.pop_front());
      end
    end
    prev_done = done;
  end

  // mode 0: plain; 1: spurious start at cycle 5 and MTHI at cycle 10;
  // 2: abort at cycle 20; 3: abort held together with start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int mode);
    int          c;
    bit          seen;
    bit          aborted;
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = hi;
    l0 = lo;
    op = o;
    rs_data = a;
    rt_data = b;
    start = 1'b1;
    if (mode == 3) abort = 1'b1;
    if (mode != 2) begin
      last_exp = ref_model(o, a, b);
      exp_q.push_back(last_exp);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    c = 0;
    seen = 1'b0;
    aborted = 1'b0;
    while (!seen && !aborted && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (mode == 1 && c == 5) begin
        start = 1'b1;
        op = 2'b00;
        rs_data = 32'h11111111;
        rt_data = 32'h00000003;
      end
      if (mode == 1 && c == 6) start = 1'b0;
      if (mode == 1 && c == 10) begin
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
      end
      if (mode == 1 && c == 11) hi_we = 1'b0;
      if (mode == 2 && c == 19) abort = 1'b1;
      if (mode == 2 && c == 20) begin
        abort = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_keep", {hi, lo}, {h0, l0});
        aborted = 1'b1;
      end
      if (c == 32) begin
        check("busy_before_fix", {63'd0, busy}, 64'd1);
        check("done_before_fix", {63'd0, done}, 64'd0);
      end
      if (done) seen = 1'b1;
    end
    if (!aborted) begin
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL timeout actual=no_done expected=done_within_40");
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end else begin
        check("latency", c, 64'd33);
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] w;
    int          sel;
    bit          wlo;

    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    rs_data = 32'd0;
    rt_data = 32'd0;
    abort = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    #12;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MTHI and MTLO together in IDLE, then abort in IDLE is harmless.
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5_0F0F;
    abort = 1'b1;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    abort = 1'b0;
    check("mt_both_idle", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});
    check("idle_abort_busy", {63'd0, busy}, 64'd0);

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("multu_max", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
    run_op(2'b01, 32'hFFFFFFFD, 32'd7, 3);
    check("mult_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
    check("div_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(2'b10, 32'd100, 32'd0, 0);
    check("divu_by_zero", {hi, lo}, {32'd100, 32'hFFFFFFFF});
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
    check("div_overflow", {hi, lo}, {32'd0, 32'h80000000});
    run_op(2'b11, 32'hFFFFFF9C, 32'd0, 0);
    check("div_by_zero_neg", {hi, lo}, {32'hFFFFFF9C, 32'hFFFFFFFF});
    run_op(2'b10, 32'd100, 32'd7, 1);
    check("divu_ignored_inputs", {hi, lo}, {32'd2, 32'd14});
    run_op(2'b00, 32'd5, 32'd6, 2);
    run_op(2'b00, 32'd5, 32'd6, 0);
    check("multu_after_abort", {hi, lo}, {32'd0, 32'd30});

    // Asynchronous reset in the middle of RUN.
    op = 2'b00;
    rs_data = 32'd9;
    rt_data = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_hilo", {hi, lo}, 64'd0);
    check("async_reset_busy", {63'd0, busy}, 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lo_we = 1'b1;
    wdata = 32'h12345678;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo_after_reset", {hi, lo}, {32'd0, 32'h12345678});

    // Randomized operations, sometimes with MTHI/MTLO in the done cycle.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end
      if (sel == 2) rb = $urandom_range(1, 15);
      if (sel == 3) ra = 32'd0;
      run_op(ro, ra, rb, 0);
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom;
        wlo = 1'($urandom_range(0, 1));
        hi_we = 1'b1;
        lo_we = wlo;
        wdata = w;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_in_done_cycle", {hi, lo}, {w, wlo ? w : last_exp[31:0]});
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
